// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: bus-facing controller for the UART receiver core.
//   Holds the receiver configuration (CTRL), gates the serial line and buffers received
//   bytes in a DEPTH-entry FIFO. The FIFO, CTRL and STATUS are reached through a
//   single-cycle register port.
// Optional feature macro: UART_RX_CTRL_IRQ_EN builds the level interrupt and CTRL[31] ie.
// Ports:
//   CLK, RST            clock and asynchronous active-low reset
//   Addr/WrEn/RdEn      register index 0 DATA, 1 CTRL, 2 STATUS, 3 CLEAR; write/read strobes
//   WData/RData         write data / registered read data
//   RX_PIN/RX_IN        serial line from the pad / gated line to the core
//   Prescale/PAR_EN/PAR_TYP  configuration driven to the core
//   P_DATA/Data_Valid   received byte and one-cycle strobe from the core
//   IRQ                 level interrupt (tied low unless UART_RX_CTRL_IRQ_EN)
module uart_rx_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  Addr,
    input  logic        WrEn,
    input  logic        RdEn,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    input  logic        RX_PIN,
    output logic        RX_IN,
    output logic [7:0]  Prescale,
    output logic        PAR_EN,
    output logic        PAR_TYP,
    input  logic [7:0]  P_DATA,
    input  logic        Data_Valid,
    output logic        IRQ
);
    localparam int unsigned PW = LW - 1;

    logic [7:0]    prescale_q, prescale_d;
    logic          par_en_q, par_en_d;
    logic          par_typ_q, par_typ_d;
    logic          rx_en_q, rx_en_d;
    logic [LW-1:0] thresh_q, thresh_d;
    logic          ovr_q, ovr_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    mem_q [DEPTH];

    logic ctrl_wr, clear_wr, empty, full, push_req, pop_req, do_push, do_pop, flush, ovr_set;
    logic ie_bit;
    logic [31:0] ctrl_val, status_val;

    assign ctrl_wr  = WrEn && (Addr == 2'd1);
    assign clear_wr = WrEn && (Addr == 2'd3);
    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign push_req = Data_Valid && rx_en_q;
    assign pop_req  = RdEn && (Addr == 2'd0);
    assign do_pop   = pop_req && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push  = push_req && (!full || do_pop);
    assign ovr_set  = push_req && full && !do_pop;
    assign flush    = clear_wr && WData[1];

    assign RX_IN    = rx_en_q ? RX_PIN : 1'b1;
    assign Prescale = prescale_q;
    assign PAR_EN   = par_en_q;
    assign PAR_TYP  = par_typ_q;
    assign RData    = rdata_q;

    always_comb begin
        ctrl_val          = '0;
        ctrl_val[7:0]     = prescale_q;
        ctrl_val[8]       = par_en_q;
        ctrl_val[9]       = par_typ_q;
        ctrl_val[10]      = rx_en_q;
        ctrl_val[11+:LW]  = thresh_q;
        ctrl_val[31]      = ie_bit;
        status_val        = '0;
        status_val[0]     = empty;
        status_val[1]     = full;
        status_val[2]     = ovr_q;
        status_val[3]     = rx_en_q;
        status_val[8+:LW] = level_q;
    end

    always_comb begin
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        rx_en_d    = rx_en_q;
        thresh_d   = thresh_q;
        if (ctrl_wr) begin
            prescale_d = WData[7:0];
            par_en_d   = WData[8];
            par_typ_d  = WData[9];
            rx_en_d    = WData[10];
            // Threshold 0 would hold IRQ permanently; store it as 1.
            thresh_d   = (WData[11+:LW] == '0) ? LW'(1) : WData[11+:LW];
        end

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_push && !do_pop)      level_d = level_q + LW'(1);
            else if (do_pop && !do_push) level_d = level_q - LW'(1);
        end

        // Set beats clear when both happen together.
        ovr_d = ovr_q;
        if (ovr_set)                     ovr_d = 1'b1;
        else if (clear_wr && WData[0])   ovr_d = 1'b0;

        rdata_d = rdata_q;
        if (RdEn) begin
            unique case (Addr)
                2'd0:    rdata_d = empty ? 32'h0 : {24'h0, mem_q[rptr_q]};
                2'd1:    rdata_d = ctrl_val;
                2'd2:    rdata_d = status_val;
                default: rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_q <= 8'd16;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            rx_en_q    <= 1'b0;
            thresh_q   <= LW'(1);
            ovr_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            rdata_q    <= '0;
        end else begin
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            rx_en_q    <= rx_en_d;
            thresh_q   <= thresh_d;
            ovr_q      <= ovr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem_q[wptr_q] <= P_DATA;
    end

`ifdef UART_RX_CTRL_IRQ_EN
    logic ie_q, ie_d, irq_q, irq_d;
    logic unused_wdata;

    always_comb begin
        ie_d  = ctrl_wr ? WData[31] : ie_q;
        irq_d = ie_q && ((level_q >= thresh_q) || ovr_q);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign ie_bit       = ie_q;
    assign IRQ          = irq_q;
    assign unused_wdata = ^WData[30:11+LW];
`else
    logic unused_wdata;
    assign ie_bit       = 1'b0;
    assign IRQ          = 1'b0;
    assign unused_wdata = ^{WData[31], WData[30:11+LW]};
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based reference model.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 8;
    localparam int LW    = 4;
`ifdef UART_RX_CTRL_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [1:0]  Addr = '0;
    logic        WrEn = 1'b0, RdEn = 1'b0;
    logic [31:0] WData = '0;
    logic [31:0] RData;
    logic        RX_PIN = 1'b0;
    logic        RX_IN;
    logic [7:0]  Prescale;
    logic        PAR_EN, PAR_TYP;
    logic [7:0]  P_DATA = '0;
    logic        Data_Valid = 1'b0;
    logic        IRQ;

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .Addr(Addr), .WrEn(WrEn), .RdEn(RdEn), .WData(WData),
        .RData(RData), .RX_PIN(RX_PIN), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO is a plain queue, registers are plain fields.
    logic [7:0]  mq[$];
    bit          m_ovr, m_pen, m_ptyp, m_rxen, m_ie, m_irq;
    logic [7:0]  m_pre;
    int          m_thr;
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr = 0; m_pen = 0; m_ptyp = 0; m_rxen = 0; m_ie = 0; m_irq = 0;
        m_pre = 8'd16; m_thr = 1; m_rdata = '0;
    endtask

    function automatic logic [31:0] m_ctrl();
        return 32'(m_pre) | (32'(m_pen) << 8) | (32'(m_ptyp) << 9) | (32'(m_rxen) << 10)
             | (32'(m_thr) << 11) | (32'(m_ie) << 31);
    endfunction

    function automatic logic [31:0] m_status();
        int n = mq.size();
        return (32'(n) << 8) | (32'(m_rxen) << 3) | (32'(m_ovr) << 2)
             | (32'(n == DEPTH) << 1) | 32'(n == 0);
    endfunction

    // One bus cycle: drive at the falling edge, update the model, check after the rising edge.
    task automatic step(input logic [1:0] a, input bit w, input bit r, input logic [31:0] wd,
                        input bit dv, input logic [7:0] pd, output logic [31:0] got);
        bit pop, push, full0, flush, clr, ovr_set, irq_n;
        @(negedge CLK);
        Addr = a; WrEn = w; RdEn = r; WData = wd; Data_Valid = dv; P_DATA = pd;
`ifdef UART_RX_CTRL_IRQ_EN
        irq_n = m_ie && ((mq.size() >= m_thr) || m_ovr);
`else
        irq_n = 0;
`endif
        if (r) begin
            case (a)
                2'd0:    m_rdata = (mq.size() > 0) ? {24'h0, mq[0]} : 32'h0;
                2'd1:    m_rdata = m_ctrl();
                2'd2:    m_rdata = m_status();
                default: m_rdata = 32'h0;
            endcase
        end
        pop     = r && (a == 2'd0) && (mq.size() > 0);
        push    = dv && m_rxen;
        full0   = (mq.size() == DEPTH);
        flush   = w && (a == 2'd3) && wd[1];
        clr     = w && (a == 2'd3) && wd[0];
        ovr_set = push && full0 && !pop;
        if (pop) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (push && !ovr_set) mq.push_back(pd);
        if (ovr_set) m_ovr = 1;
        else if (clr) m_ovr = 0;
        if (w && (a == 2'd1)) begin
            m_pre  = wd[7:0];
            m_pen  = wd[8];
            m_ptyp = wd[9];
            m_rxen = wd[10];
            m_thr  = (wd[14:11] == 4'd0) ? 1 : int'(wd[14:11]);
`ifdef UART_RX_CTRL_IRQ_EN
            m_ie   = wd[31];
`endif
        end
        m_irq = irq_n;
        @(posedge CLK);
        #1;
        got = RData;
        WrEn = 0; RdEn = 0; Data_Valid = 0;
        chk("rdata", RData, m_rdata);
        chk("irq", 32'(IRQ), 32'(m_irq));
        chk("prescale", 32'(Prescale), 32'(m_pre));
        chk("par_en", 32'(PAR_EN), 32'(m_pen));
        chk("par_typ", 32'(PAR_TYP), 32'(m_ptyp));
        chk("rx_in", 32'(RX_IN), m_rxen ? 32'(RX_PIN) : 32'd1);
    endtask

    task automatic idle();
        logic [31:0] g;
        step(2'd0, 0, 0, 32'h0, 0, 8'h0, g);
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] g;
        step(a, 1, 0, d, 0, 8'h0, g);
    endtask
    task automatic rd(input logic [1:0] a, output logic [31:0] g);
        step(a, 0, 1, 32'h0, 0, 8'h0, g);
    endtask
    task automatic push(input logic [7:0] b);
        logic [31:0] g;
        step(2'd0, 0, 0, 32'h0, 1, b, g);
    endtask

    typedef struct {
        logic [1:0]  addr;
        bit          wr;
        bit          rd;
        logic [31:0] wdata;
        bit          dv;
        logic [7:0]  pdata;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] g;

        vecs[0]  = '{2'd1, 0, 1, 32'h0,   0, 8'h00, 1, 32'h0000_0810};
        vecs[1]  = '{2'd2, 0, 1, 32'h0,   0, 8'h00, 1, 32'h0000_0001};
        vecs[2]  = '{2'd1, 1, 0, 32'h508, 0, 8'h00, 0, 32'h0};
        vecs[3]  = '{2'd1, 0, 1, 32'h0,   0, 8'h00, 1, 32'h0000_0D08};
        vecs[4]  = '{2'd0, 0, 0, 32'h0,   1, 8'hA5, 0, 32'h0};
        vecs[5]  = '{2'd0, 0, 0, 32'h0,   1, 8'h3C, 0, 32'h0};
        vecs[6]  = '{2'd2, 0, 1, 32'h0,   0, 8'h00, 1, 32'h0000_0208};
        vecs[7]  = '{2'd0, 0, 1, 32'h0,   0, 8'h00, 1, 32'h0000_00A5};
        vecs[8]  = '{2'd0, 0, 1, 32'h0,   0, 8'h00, 1, 32'h0000_003C};
        vecs[9]  = '{2'd0, 0, 1, 32'h0,   0, 8'h00, 1, 32'h0000_0000};
        vecs[10] = '{2'd2, 0, 1, 32'h0,   0, 8'h00, 1, 32'h0000_0009};

        // Reset state
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_rdata", RData, 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        chk("rst_rx_in", 32'(RX_IN), 32'h1);
        chk("rst_prescale", 32'(Prescale), 32'd16);
        chk("rst_par", {30'h0, PAR_EN, PAR_TYP}, 32'h0);
        @(negedge CLK);
        RST = 1'b1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata, vecs[i].dv,
                 vecs[i].pdata, g);
            if (vecs[i].chk) chk($sformatf("vec%0d", i), g, vecs[i].exp);
        end

        // Overrun: ninth byte dropped, then clear overrun and flush
        for (int i = 1; i <= 9; i++) push(8'(i));
        rd(2'd2, g); chk("ovr_status", g, 32'h0000_080E);
        wr(2'd3, 32'h1);
        rd(2'd2, g); chk("ovr_cleared", g, 32'h0000_080A);
        wr(2'd3, 32'h2);
        rd(2'd2, g); chk("flushed", g, 32'h0000_0009);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        step(2'd0, 0, 1, 32'h0, 1, 8'hEE, g); chk("full_pp_pop", g, 32'h10);
        rd(2'd2, g); chk("full_pp_status", g, 32'h0000_080A);
        for (int i = 1; i < 8; i++) begin
            rd(2'd0, g); chk("full_pp_drain", g, 32'h10 + 32'(i));
        end
        rd(2'd0, g); chk("full_pp_last", g, 32'hEE);

        // Interrupt threshold
        wr(2'd1, 32'h8000_1C10);
        push(8'h01); push(8'h02); idle();
        chk("irq_below", 32'(IRQ), 32'h0);
        push(8'h03);
        chk("irq_same_cycle", 32'(IRQ), 32'h0);
        idle();
        chk("irq_at_thr", 32'(IRQ), 32'(IRQ_ON));
        rd(2'd0, g);
        chk("irq_pop_cycle", 32'(IRQ), 32'(IRQ_ON));
        idle();
        chk("irq_after_pop", 32'(IRQ), 32'h0);
        wr(2'd3, 32'h2);

        // Receiver disabled: line forced idle, strobe ignored
        wr(2'd1, 32'h10);
        RX_PIN = 1'b0;
        idle();
        chk("rx_gated", 32'(RX_IN), 32'h1);
        push(8'h55);
        rd(2'd2, g); chk("rx_off_status", g, 32'h0000_0001);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int op;
            logic [31:0] wd;
            RX_PIN = 1'($urandom);
            op = $urandom_range(0, 9);
            wd = $urandom;
            if (op <= 4) begin
                step(2'($urandom), 0, 1, 32'h0, 1'($urandom), 8'($urandom), g);
            end else if (op == 5) begin
                wd[10] = ($urandom_range(0, 4) != 0);
                step(2'd1, 1, 0, wd, 1'($urandom), 8'($urandom), g);
            end else if (op == 6) begin
                step(2'd3, 1, 0, 32'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), g);
            end else if (op == 7) begin
                step(($urandom_range(0, 1) != 0) ? 2'd0 : 2'd2, 1, 0, wd, 1'($urandom),
                     8'($urandom), g);
            end else begin
                step(2'd0, 0, 0, 32'h0, 1'($urandom), 8'($urandom), g);
            end
        end

        // Asynchronous reset mid-operation
        wr(2'd1, 32'h400);
        push(8'h77); push(8'h88);
        rd(2'd1, g);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("midrst_rdata", RData, 32'h0);
        chk("midrst_rx_in", 32'(RX_IN), 32'h1);
        chk("midrst_prescale", 32'(Prescale), 32'd16);
        chk("midrst_irq", 32'(IRQ), 32'h0);
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        rd(2'd2, g); chk("midrst_status", g, 32'h0000_0001);
        rd(2'd1, g); chk("midrst_ctrl", g, 32'h0000_0810);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
